// File: rtl/block_intersector_if.sv
`default_nettype none
// ============================================================================
//  Module   : block_intersector_if
//  Brief    : Stop-key, operand and result bundle between the player input,
//             block_tracker and block_intersector.
//  Revision : 1.0 - initial release
// ============================================================================
interface block_intersector_if;
    logic       stop_btn;
    logic [8:0] move_block_start;
    logic [3:0] move_block_size;
    logic [8:0] prev_block_start;
    logic [8:0] prev_block_end;
    logic [3:0] prev_block_size;
    logic [8:0] inter_block_start;
    logic [8:0] inter_block_end;
    logic [3:0] inter_block_size;
    logic       intersect_true;
    logic       stop_true;
    logic       busy;
    logic       game_over;

    // Driver of the stop key and operands; consumer of the trimmed block
    modport master (
        output stop_btn, move_block_start, move_block_size,
               prev_block_start, prev_block_end, prev_block_size,
        input  inter_block_start, inter_block_end, inter_block_size,
               intersect_true, stop_true, busy, game_over
    );

    // The intersector itself
    modport slave (
        input  stop_btn, move_block_start, move_block_size,
               prev_block_start, prev_block_end, prev_block_size,
        output inter_block_start, inter_block_end, inter_block_size,
               intersect_true, stop_true, busy, game_over
    );
endinterface
`default_nettype wire

// File: rtl/block_intersector.sv
`default_nettype none
// ============================================================================
//  Module   : block_intersector
//  Brief    : On a stop-key press, overlaps the moving block with the last
//             placed block, trims it to whole units and reports the result
//             with a one-cycle stop_true pulse. A miss latches game_over.
//  Revision : 1.0 - initial release
// ============================================================================
module block_intersector #(
    parameter int UNIT_W   = 16,
    parameter int SCREEN_W = 320
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    block_intersector_if.slave bus
);

    localparam int         c_SHIFT = $clog2(UNIT_W);
    localparam logic [9:0] c_XMAX  = 10'(SCREEN_W - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LATCH    = 3'd1;
    localparam logic [2:0] c_COMPARE  = 3'd2;
    localparam logic [2:0] c_RESULT   = 3'd3;
    localparam logic [2:0] c_GAMEOVER = 3'd4;

    logic [2:0] r_state, w_next_state;
    logic       r_btn_q;

    // Operands frozen at capture so input changes while busy are harmless
    logic [8:0] r_m_start, r_p_start, r_p_end, r_m_end, r_ov_s;
    logic [3:0] r_m_size, r_p_size, r_units;

    logic [8:0] r_inter_start, r_inter_end;
    logic [3:0] r_inter_size;
    logic       r_intersect, r_stop_true, r_game_over;

    logic       w_event, w_busy, w_capture, w_latch, w_compare, w_result;
    logic [9:0] w_m_end_raw, w_width, w_units_raw;
    logic [8:0] w_m_end, w_ov_s, w_ov_e, w_res_end;
    logic [3:0] w_units;
    logic       w_hit;

    assign w_event = bus.stop_btn & ~r_btn_q;

    // Moving block right edge, widened to 10 bits so the clamp sees overflow
    assign w_m_end_raw = {1'b0, r_m_start} + ({6'b0, r_m_size} << c_SHIFT) - 10'd1;
    assign w_m_end     = (w_m_end_raw > c_XMAX) ? c_XMAX[8:0] : w_m_end_raw[8:0];

    // Overlap window; with no block placed yet the whole moving block counts
    assign w_ov_s      = (r_p_size == 4'd0) ? r_m_start
                       : ((r_m_start > r_p_start) ? r_m_start : r_p_start);
    assign w_ov_e      = (r_p_size == 4'd0) ? r_m_end
                       : ((r_m_end < r_p_end) ? r_m_end : r_p_end);
    assign w_hit       = (w_ov_s <= w_ov_e);
    assign w_width     = {1'b0, w_ov_e} - {1'b0, w_ov_s} + 10'd1;
    assign w_units_raw = w_width >> c_SHIFT;
    assign w_units     = !w_hit ? 4'd0
                       : ((w_units_raw > 10'd15) ? 4'd15 : w_units_raw[3:0]);

    // Right edge trimmed back to a whole number of units; always fits 9 bits
    assign w_res_end   = r_ov_s + ({5'b0, r_units} << c_SHIFT) - 9'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= c_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (w_event) w_next_state = c_LATCH;
            c_LATCH:    w_next_state = c_COMPARE;
            c_COMPARE:  w_next_state = c_RESULT;
            c_RESULT:   w_next_state = (r_units == 4'd0) ? c_GAMEOVER : c_IDLE;
            c_GAMEOVER: w_next_state = c_GAMEOVER;
            default:    w_next_state = c_IDLE;
        endcase
    end

    // Per-state strobes for the datapath
    always_comb begin
        w_busy    = 1'b0;
        w_capture = 1'b0;
        w_latch   = 1'b0;
        w_compare = 1'b0;
        w_result  = 1'b0;
        case (r_state)
            c_IDLE:    w_capture = w_event;
            c_LATCH:   begin w_busy = 1'b1; w_latch   = 1'b1; end
            c_COMPARE: begin w_busy = 1'b1; w_compare = 1'b1; end
            c_RESULT:  begin w_busy = 1'b1; w_result  = 1'b1; end
            default:   w_busy = 1'b0;
        endcase
    end

    // Datapath: edge detector, operand capture, pipeline steps, held results
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_btn_q       <= 1'b1;   // a key held through reset must not fire
            r_m_start     <= '0;
            r_m_size      <= '0;
            r_p_start     <= '0;
            r_p_end       <= '0;
            r_p_size      <= '0;
            r_m_end       <= '0;
            r_ov_s        <= '0;
            r_units       <= '0;
            r_inter_start <= '0;
            r_inter_end   <= '0;
            r_inter_size  <= '0;
            r_intersect   <= 1'b0;
            r_stop_true   <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_btn_q     <= bus.stop_btn;
            r_stop_true <= 1'b0;
            if (w_capture) begin
                r_m_start <= bus.move_block_start;
                r_m_size  <= bus.move_block_size;
                r_p_start <= bus.prev_block_start;
                r_p_end   <= bus.prev_block_end;
                r_p_size  <= bus.prev_block_size;
            end
            if (w_latch) r_m_end <= w_m_end;
            if (w_compare) begin
                r_ov_s  <= w_ov_s;
                r_units <= w_units;
            end
            if (w_result) begin
                r_stop_true <= 1'b1;
                r_intersect <= (r_units != 4'd0);
                if (r_units == 4'd0) begin
                    r_inter_start <= '0;
                    r_inter_end   <= '0;
                    r_inter_size  <= '0;
                    r_game_over   <= 1'b1;
                end else begin
                    r_inter_start <= r_ov_s;
                    r_inter_end   <= w_res_end;
                    r_inter_size  <= r_units;
                end
            end
        end
    end

    assign bus.inter_block_start = r_inter_start;
    assign bus.inter_block_end   = r_inter_end;
    assign bus.inter_block_size  = r_inter_size;
    assign bus.intersect_true    = r_intersect;
    assign bus.stop_true         = r_stop_true;
    assign bus.busy              = w_busy;
    assign bus.game_over         = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_block_intersector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_intersector
//  Brief    : Self-checking bench for block_intersector: directed game
//             scenarios plus randomized drops against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_block_intersector;

    localparam int UNIT_W   = 16;
    localparam int SCREEN_W = 320;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    block_intersector_if bus();

    block_intersector #(.UNIT_W(UNIT_W), .SCREEN_W(SCREEN_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural overlap model in plain integer arithmetic
    function automatic void ref_model(input int ms, input int msz, input int ps,
                                      input int pe, input int psz,
                                      output int s, output int e, output int sz,
                                      output int hit);
        int m_end, os, oe, u;
        m_end = ms + msz * UNIT_W - 1;
        if (m_end > SCREEN_W - 1) m_end = SCREEN_W - 1;
        if (psz == 0) begin
            os = ms; oe = m_end;
        end else begin
            os = (ms > ps) ? ms : ps;
            oe = (m_end < pe) ? m_end : pe;
        end
        u = (os <= oe) ? (oe - os + 1) / UNIT_W : 0;
        if (u > 15) u = 15;
        if (u == 0) begin
            s = 0; e = 0; sz = 0; hit = 0;
        end else begin
            s = os; e = os + u * UNIT_W - 1; sz = u; hit = 1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        bus.stop_btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_ops(input int ms, input int msz, input int ps, input int pe, input int psz);
        bus.move_block_start = 9'(ms);
        bus.move_block_size  = 4'(msz);
        bus.prev_block_start = 9'(ps);
        bus.prev_block_end   = 9'(pe);
        bus.prev_block_size  = 4'(psz);
    endtask

    // Press the key, wait (bounded) for stop_true, release; lat counts edges after the sampling edge
    task automatic press(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        @(negedge clk);
        bus.stop_btn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.stop_true === 1'b1) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        @(negedge clk);
        bus.stop_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.inter_block_start, bus.inter_block_end, bus.inter_block_size, bus.intersect_true,
             bus.stop_true, bus.busy, bus.game_over} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got start=%0d end=%0d size=%0d inter=%b stop=%b busy=%b go=%b want all 0",
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.stop_true, bus.busy, bus.game_over);
        end
    endtask

    task automatic test_first_block();
        bit got; int lat;
        do_reset();
        set_ops(40, 5, 0, 0, 0);
        press(got, lat);
        total++;
        if (!got || lat != 3) begin
            bad++;
            $display("FAIL first_latency: got seen=%0d lat=%0d want seen=1 lat=3", got, lat);
        end
        total++;
        if ({bus.inter_block_start, bus.inter_block_end, bus.inter_block_size, bus.intersect_true, bus.game_over}
            !== {9'd40, 9'd119, 4'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL first_result: got %0d/%0d/%0d i=%b go=%b want 40/119/5 i=1 go=0",
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.game_over);
        end
        total++;
        if (bus.stop_true !== 1'b0) begin
            bad++;
            $display("FAIL stop_pulse_width: got stop_true=%b want 0 after result", bus.stop_true);
        end
    endtask

    task automatic test_partial_exact();
        bit got; int lat;
        set_ops(120, 4, 100, 163, 4);
        press(got, lat);
        total++;
        if (!got || {bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.game_over} !== {9'd120, 9'd151, 4'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL partial: got seen=%0d %0d/%0d/%0d i=%b go=%b want 120/151/2 i=1 go=0", got,
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.game_over);
        end
        set_ops(100, 4, 100, 163, 4);
        press(got, lat);
        total++;
        if (!got || {bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true} !== {9'd100, 9'd163, 4'd4, 1'b1}) begin
            bad++;
            $display("FAIL exact: got seen=%0d %0d/%0d/%0d i=%b want 100/163/4 i=1", got,
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size, bus.intersect_true);
        end
    endtask

    task automatic test_sliver_miss();
        bit got; int lat;
        set_ops(150, 4, 100, 163, 4);
        press(got, lat);
        total++;
        if (!got || {bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.game_over} !== {9'd0, 9'd0, 4'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sliver: got seen=%0d %0d/%0d/%0d i=%b go=%b want 0/0/0 i=0 go=1", got,
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.game_over);
        end
        set_ops(100, 4, 100, 163, 4);
        press(got, lat);
        total++;
        if (got || bus.game_over !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL press_after_gameover: got stop=%0d go=%b busy=%b want stop=0 go=1 busy=0",
                     got, bus.game_over, bus.busy);
        end
    endtask

    task automatic test_miss();
        bit got; int lat;
        do_reset();
        set_ops(200, 4, 100, 163, 4);
        press(got, lat);
        total++;
        if (!got || bus.intersect_true !== 1'b0 || bus.game_over !== 1'b1 || bus.inter_block_size !== 4'd0) begin
            bad++;
            $display("FAIL miss: got seen=%0d i=%b go=%b size=%0d want seen=1 i=0 go=1 size=0",
                     got, bus.intersect_true, bus.game_over, bus.inter_block_size);
        end
    endtask

    task automatic test_held_key();
        int pulses;
        do_reset();
        set_ops(40, 5, 0, 0, 0);
        pulses = 0;
        @(negedge clk);
        bus.stop_btn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.stop_true === 1'b1) pulses++;
        end
        @(negedge clk);
        bus.stop_btn = 1'b0;
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL held_key: got pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_busy_press();
        int pulses;
        do_reset();
        set_ops(120, 4, 100, 163, 4);
        pulses = 0;
        @(negedge clk);
        bus.stop_btn = 1'b1;
        @(posedge clk); #1;                  // event sampled here
        @(negedge clk);
        bus.stop_btn = 1'b0;
        set_ops(300, 15, 0, 0, 0);           // must not leak into the result
        @(posedge clk); #1;
        if (bus.stop_true === 1'b1) pulses++;
        @(negedge clk);
        bus.stop_btn = 1'b1;                 // second press while busy
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.stop_true === 1'b1) pulses++;
        end
        @(negedge clk);
        bus.stop_btn = 1'b0;
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL busy_press: got pulses=%0d want 1", pulses);
        end
        total++;
        if ({bus.inter_block_start, bus.inter_block_end, bus.inter_block_size} !== {9'd120, 9'd151, 4'd2}) begin
            bad++;
            $display("FAIL frozen_operands: got %0d/%0d/%0d want 120/151/2",
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size);
        end
    endtask

    task automatic test_reset_in_compare();
        int pulses;
        do_reset();
        set_ops(40, 5, 0, 0, 0);
        pulses = 0;
        @(negedge clk);
        bus.stop_btn = 1'b1;
        @(posedge clk); #1;                  // IDLE -> LATCH
        @(posedge clk); #1;                  // LATCH -> COMPARE
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        if (bus.stop_true === 1'b1) pulses++;
        @(negedge clk);
        resetn = 1'b1;                       // key still held: must not fire
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.stop_true === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_in_compare: got pulses=%0d want 0", pulses);
        end
        total++;
        if ({bus.inter_block_start, bus.inter_block_end, bus.inter_block_size, bus.intersect_true,
             bus.busy, bus.game_over} !== 27'd0) begin
            bad++;
            $display("FAIL reset_in_compare_outputs: got %0d/%0d/%0d i=%b busy=%b go=%b want all 0",
                     bus.inter_block_start, bus.inter_block_end, bus.inter_block_size,
                     bus.intersect_true, bus.busy, bus.game_over);
        end
        @(negedge clk);
        bus.stop_btn = 1'b0;
    endtask

    task automatic test_held_through_reset();
        int busy_seen;
        busy_seen = 0;
        @(negedge clk);
        bus.stop_btn = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1 || bus.stop_true === 1'b1) busy_seen++;
        end
        @(negedge clk);
        bus.stop_btn = 1'b0;
        total++;
        if (busy_seen != 0) begin
            bad++;
            $display("FAIL held_through_reset: got active cycles=%0d want 0", busy_seen);
        end
    endtask

    task automatic test_random();
        bit got; int lat;
        int ms, msz, ps, pe, psz, s, e, sz, hit;
        for (int n = 0; n < 30; n++) begin
            do_reset();
            ms  = int'($urandom_range(0, SCREEN_W - 1));
            msz = int'($urandom_range(1, 15));
            ps  = int'($urandom_range(0, SCREEN_W - 1));
            psz = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
            pe  = ps + psz * UNIT_W - 1;
            if (pe > SCREEN_W - 1) pe = SCREEN_W - 1;
            if (psz == 0) begin ps = 0; pe = 0; end
            if (n % 3 == 0 && psz != 0) ms = ps + int'($urandom_range(0, 20)) - 10;
            if (ms < 0) ms = 0;
            if (ms > SCREEN_W - 1) ms = SCREEN_W - 1;
            ref_model(ms, msz, ps, pe, psz, s, e, sz, hit);
            set_ops(ms, msz, ps, pe, psz);
            press(got, lat);
            total++;
            if (!got || lat != 3) begin
                bad++;
                $display("FAIL rand_stop[%0d]: got seen=%0d lat=%0d want seen=1 lat=3", n, got, lat);
            end
            total++;
            if ({bus.inter_block_start, bus.inter_block_end, bus.inter_block_size}
                !== {9'(s), 9'(e), 4'(sz)}) begin
                bad++;
                $display("FAIL rand_block[%0d] m=%0d/%0d p=%0d..%0d/%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         n, ms, msz, ps, pe, psz, bus.inter_block_start, bus.inter_block_end,
                         bus.inter_block_size, s, e, sz);
            end
            total++;
            if (bus.intersect_true !== 1'(hit) || bus.game_over !== 1'(!hit)) begin
                bad++;
                $display("FAIL rand_flags[%0d]: got i=%b go=%b want i=%0d go=%0d",
                         n, bus.intersect_true, bus.game_over, hit, !hit);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        bus.stop_btn = 1'b0;
        set_ops(0, 0, 0, 0, 0);
        test_reset();
        test_first_block();
        test_partial_exact();
        test_sliver_miss();
        test_miss();
        test_held_key();
        test_busy_press();
        test_reset_in_compare();
        test_held_through_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
